status_led_ctrl: RTL and testbench

STATUS_LED_CTRL -- requirements
Module: status_led_ctrl

---
 rtl/status_led_ctrl.sv | 144 ++++++++++++++
 tb/tb_status_led_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_led_ctrl.sv
`default_nettype none
// =====================================================================
// status_led_ctrl : per-channel link-speed / activity status LED driver
// Rev 1.0 - initial release
// =====================================================================
module status_led_ctrl #(
   parameter int CH_COUNT       = 4,
   parameter int FLASH_BIT      = 25,
   parameter int ACT_FLASH_BIT  = 22,
   parameter int ACT_STRETCH    = 5_000_000,
   parameter int PWM_FULL       = 2000,
   parameter int BREATH_HOLD    = 4,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset_n,
   input  logic [2*CH_COUNT-1:0] link_st,
   input  logic [CH_COUNT-1:0]   activity,
   input  logic                  lamp_test,
   output logic [CH_COUNT-1:0]   led_out
);

   localparam int c_PWM_W  = $clog2(PWM_FULL + 1);
   localparam int c_HOLD_W = (BREATH_HOLD > 1) ? $clog2(BREATH_HOLD) : 1;
   localparam int c_STR_W  = $clog2(ACT_STRETCH + 1);

   localparam logic [c_PWM_W-1:0]  c_PWM_LAST  = c_PWM_W'(PWM_FULL - 1);
   localparam logic [c_PWM_W-1:0]  c_DUTY_TOP  = c_PWM_W'(PWM_FULL);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(BREATH_HOLD - 1);
   localparam logic [c_STR_W-1:0]  c_STR_LOAD  = c_STR_W'(ACT_STRETCH - 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_STRETCH = 1'b1
   } ch_state_t;

   logic [FLASH_BIT:0]    r_flash_cnt;
   logic [c_PWM_W-1:0]    r_pwm_cnt;
   logic [c_PWM_W-1:0]    r_duty;
   logic                  r_duty_falling;
   logic [c_HOLD_W-1:0]   r_hold_cnt;
   logic                  w_pwm_wrap;
   logic                  w_duty_step;
   logic                  w_breath;
   logic [CH_COUNT-1:0]   w_lit;

   assign w_pwm_wrap  = (r_pwm_cnt == c_PWM_LAST);
   assign w_duty_step = w_pwm_wrap && (r_hold_cnt == c_HOLD_LAST);
   assign w_breath    = (r_pwm_cnt < r_duty);

   // Shared timebase: flash counter, PWM period and triangle duty ramp
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_flash_cnt    <= '0;
         r_pwm_cnt      <= '0;
         r_duty         <= '0;
         r_duty_falling <= 1'b0;
         r_hold_cnt     <= '0;
      end else begin
         r_flash_cnt <= r_flash_cnt + 1'b1;
         if (w_pwm_wrap) begin
            r_pwm_cnt  <= '0;
            r_hold_cnt <= w_duty_step ? '0 : r_hold_cnt + 1'b1;
         end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
         end
         if (w_duty_step) begin
            if (!r_duty_falling) begin
               if (r_duty == c_DUTY_TOP) begin
                  r_duty_falling <= 1'b1;
                  r_duty         <= r_duty - 1'b1;
               end else begin
                  r_duty         <= r_duty + 1'b1;
               end
            end else begin
               if (r_duty == '0) begin
                  r_duty_falling <= 1'b0;
                  r_duty         <= r_duty + 1'b1;
               end else begin
                  r_duty         <= r_duty - 1'b1;
               end
            end
         end
      end
   end

   for (genvar ch = 0; ch < CH_COUNT; ch++) begin : g_ch
      ch_state_t          r_state;
      logic [c_STR_W-1:0] r_str_cnt;
      logic [1:0]         w_link;

      assign w_link = link_st[2*ch +: 2];

      // Link loss wins over any activity pulse in the same clock
      always_ff @(posedge sys_clk or negedge sys_reset_n) begin
         if (!sys_reset_n) begin
            r_state   <= ST_IDLE;
            r_str_cnt <= '0;
         end else if (w_link == 2'b00) begin
            r_state   <= ST_IDLE;
            r_str_cnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (activity[ch]) begin
                     r_state   <= ST_STRETCH;
                     r_str_cnt <= c_STR_LOAD;
                  end
               end
               ST_STRETCH: begin
                  if (activity[ch]) begin
                     r_str_cnt <= c_STR_LOAD;
                  end else if (r_str_cnt == '0) begin
                     r_state   <= ST_IDLE;
                  end else begin
                     r_str_cnt <= r_str_cnt - 1'b1;
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_str_cnt <= '0;
               end
            endcase
         end
      end

      assign w_lit[ch] = lamp_test                ? 1'b1 :
                         (w_link == 2'b00)        ? 1'b0 :
                         (r_state == ST_STRETCH)  ? r_flash_cnt[ACT_FLASH_BIT] :
                         (w_link == 2'b10)        ? 1'b1 :
                         (w_link == 2'b01)        ? w_breath :
                                                    r_flash_cnt[FLASH_BIT];
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         led_out <= {CH_COUNT{LED_ACTIVE_LOW}};
      end else begin
         led_out <= w_lit ^ {CH_COUNT{LED_ACTIVE_LOW}};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_status_led_ctrl.sv
`default_nettype none
// =====================================================================
// tb_status_led_ctrl : scoreboard bench for status_led_ctrl
// Stimulus queues expected led_out per cycle; a negedge monitor pops
// and compares.
// Rev 1.0 - initial release
// =====================================================================
module tb_status_led_ctrl;

    localparam int CH = 4;

    logic            sys_clk     = 1'b0;
    logic            sys_reset_n = 1'b0;
    logic [2*CH-1:0] link_st     = '0;
    logic [CH-1:0]   activity    = '0;
    logic            lamp_test   = 1'b0;
    logic [CH-1:0]   led_out;

    status_led_ctrl #(
        .CH_COUNT      (CH),
        .FLASH_BIT     (3),
        .ACT_FLASH_BIT (1),
        .ACT_STRETCH   (10),
        .PWM_FULL      (4),
        .BREATH_HOLD   (1),
        .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_reset_n(sys_reset_n),
        .link_st    (link_st),
        .activity   (activity),
        .lamp_test  (lamp_test),
        .led_out    (led_out)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            cyc;
        logic [CH-1:0] mask;
        logic [CH-1:0] val;
        string         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   rel      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   r_done   = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.cyc != cyc || ((led_out ^ mon_e.val) & mon_e.mask) != '0) begin
                n_fail++;
                $display("FAIL %s: cycle %0d (due %0d) led_out=%b expected=%b mask=%b",
                         mon_e.tag, cyc, mon_e.cyc, led_out, mon_e.val, mon_e.mask);
            end
        end
    end

    initial begin
        #200000;
        if (!r_done) begin
            n_fail++;
            $display("FAIL timeout: test sequence did not complete, cycle %0d", cyc);
            $finish;
        end
    end

    task automatic sb_push(input int c, input logic [CH-1:0] mask,
                           input logic [CH-1:0] val, input string tag);
        exp_t e;
        int   i;
        e.cyc = c; e.mask = mask; e.val = val; e.tag = tag;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_fsm_idle(input int ch, input string tag);
        logic       st;
        logic [3:0] cnt;
        case (ch)
            0:       begin st = dut.g_ch[0].r_state; cnt = 4'(dut.g_ch[0].r_str_cnt); end
            1:       begin st = dut.g_ch[1].r_state; cnt = 4'(dut.g_ch[1].r_str_cnt); end
            2:       begin st = dut.g_ch[2].r_state; cnt = 4'(dut.g_ch[2].r_str_cnt); end
            default: begin st = dut.g_ch[3].r_state; cnt = 4'(dut.g_ch[3].r_str_cnt); end
        endcase
        n_checks++;
        if (st !== 1'b0 || cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL %s: cycle %0d ch%0d state=%b str_cnt=%0d expected IDLE/0",
                     tag, cyc, ch, st, cnt);
        end
    endtask

    function automatic logic flash_bit(input int m, input int b);
        int j;
        j = m - 1 - rel;
        return ((j >> b) & 1) != 0;
    endfunction

    function automatic logic breath_lit(input int m);
        int j, t, duty;
        j    = m - 1 - rel;
        t    = (j / 4) % 8;
        duty = (t <= 4) ? t : 8 - t;
        return (j % 4) < duty;
    endfunction

    task automatic stretch_run(input int second);
        int n, last, m;
        logic [CH-1:0] v;
        n    = cyc;
        last = (second == 0) ? n + 10 : n + second + 10;
        for (int k = 1; k <= 22; k++) begin
            m = n + k;
            if (m >= n + 2 && m <= last + 1) v = {2'b00, ~flash_bit(m, 1), 1'b0};
            else                             v = 4'b0000;
            sb_push(m, 4'hF, v, (second == 0) ? "stretch_single" : "stretch_retrigger");
        end
        activity[1] = 1'b1;
        tick();
        activity = '0;
        if (second > 0) begin
            repeat (second - 1) tick();
            activity[1] = 1'b1;
            tick();
            activity = '0;
        end
        while (cyc < n + 22) tick();
    endtask

    initial begin
        int n, m;
        logic [CH-1:0] v;

        repeat (3) tick();
        sb_push(cyc, 4'hF, 4'hF, "reset_dark");
        link_st = 8'b10_10_10_10;
        sb_push(cyc + 1, 4'hF, 4'hF, "reset_hold");
        tick();
        sys_reset_n = 1'b1;
        rel = cyc;
        sb_push(cyc + 1, 4'hF, 4'h0, "solid_on");
        tick(); tick();

        link_st = 8'b10_10_10_11;
        for (int k = 1; k <= 32; k++) begin
            m = cyc + k;
            sb_push(m, 4'hF, {3'b000, ~flash_bit(m, 3)}, "flash_10m");
        end
        repeat (32) tick();

        link_st = 8'b10_10_10_10;
        stretch_run(0);
        stretch_run(5);

        n = cyc;
        for (int k = 1; k <= 18; k++) begin
            m = n + k;
            if (k == 2 || k == 3)      v = {1'b0, ~flash_bit(m, 1), 2'b00};
            else if (k >= 4 && k <= 6) v = 4'b0100;
            else                       v = 4'b0000;
            sb_push(m, 4'hF, v, "link_drop");
        end
        activity[2] = 1'b1;
        tick();
        activity = '0;
        tick(); tick();
        link_st[5:4] = 2'b00;
        activity[2]  = 1'b1;
        tick();
        activity = '0;
        tick();
        activity[2] = 1'b1;
        tick();
        activity = '0;
        link_st[5:4] = 2'b10;
        while (cyc < n + 18) tick();

        link_st = 8'b01_10_10_10;
        for (int k = 1; k <= 40; k++) begin
            m = cyc + k;
            sb_push(m, 4'hF, {~breath_lit(m), 3'b000}, "breathing");
        end
        repeat (40) tick();

        n = cyc;
        link_st     = 8'b11_00_10_10;
        lamp_test   = 1'b1;
        activity[1] = 1'b1;
        for (int k = 1; k <= 4; k++) sb_push(n + k, 4'hF, 4'h0, "lamp_test");
        sb_push(n + 5, 4'b0100, 4'b0100, "lamp_release");
        tick();
        activity = '0;
        tick(); tick(); tick();
        lamp_test = 1'b0;
        repeat (15) tick();

        link_st = 8'b01_10_10_10;
        activity[0] = 1'b1;
        tick();
        activity = '0;
        tick(); tick();
        sb_push(cyc, 4'hF, 4'hF, "reset_async");
        sb_push(cyc + 1, 4'hF, 4'hF, "reset_mid_hold");
        sb_push(cyc + 2, 4'hF, 4'hF, "reset_mid_hold");
        sys_reset_n = 1'b0;
        tick(); tick();
        check_fsm_idle(0, "reset_mid_fsm");
        check_fsm_idle(1, "reset_mid_fsm");
        sys_reset_n = 1'b1;
        rel = cyc;
        check_fsm_idle(0, "post_reset_fsm");
        for (int k = 1; k <= 16; k++) begin
            m = cyc + k;
            sb_push(m, 4'hF, {~breath_lit(m), 3'b000}, "post_reset");
        end
        repeat (16) tick();

        repeat (3) tick();
        r_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
